// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit with a start/busy/done handshake.
// One bit per cycle: shift-add multiply or restoring divide on operand
// magnitudes, followed by a sign-fix cycle that also resolves special cases.
// Optional macro MULDIV_FAST_PATH_EN: trivial ops (zero divisor, zero
// multiply operand) go straight from IDLE to DONE with a one-cycle latency.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_acc;     // mul: {product hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] r_opd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]       r_f3;
  logic             r_neg;     // product/quotient negation
  logic             r_sa;      // remainder negation (dividend sign)
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_a_sgn, w_b_sgn;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_mul_sum, w_rem_sh, w_diff;
  logic [AW-1:0]    w_mul_acc, w_div_acc, w_prod;
  logic [WIDTH-1:0] w_q, w_r, w_fix_res, w_res_d;

  // Operand sign decode and magnitudes for the incoming request
  always_comb begin
    w_a_sgn = a[WIDTH-1] & ((~funct3[2] & (funct3[1:0] != 2'b11)) | (funct3[2] & ~funct3[0]));
    w_b_sgn = b[WIDTH-1] & ((~funct3[2] & ~funct3[1]) | (funct3[2] & ~funct3[0]));
    w_a_mag = w_a_sgn ? WIDTH'(-a) : a;
    w_b_mag = w_b_sgn ? WIDTH'(-b) : b;
  end

  // One iteration step of shift-add multiply and restoring divide
  always_comb begin
    w_mul_sum = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_rem_sh  = r_acc[AW-1:WIDTH-1];
    w_diff    = w_rem_sh - {1'b0, r_opd};
    w_div_acc = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                              : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction and result selection; zero divisor handled here
  always_comb begin
    w_prod    = r_neg ? AW'(-r_acc) : r_acc;
    w_q       = r_acc[WIDTH-1:0];
    w_r       = r_acc[AW-1:WIDTH];
    w_fix_res = '0;
    case (r_f3)
      3'b000:         w_fix_res = w_prod[WIDTH-1:0];
      3'b001, 3'b010,
      3'b011:         w_fix_res = w_prod[AW-1:WIDTH];
      3'b100, 3'b101: w_fix_res = (r_opd == '0) ? '1 : (r_neg ? WIDTH'(-w_q) : w_q);
      default:        w_fix_res = r_sa ? WIDTH'(-w_r) : w_r;
    endcase
`ifdef MULDIV_FAST_PATH_EN
    if (r_state == S_IDLE)
      w_res_d = funct3[2] ? (funct3[1] ? a : '1) : '0;
    else
      w_res_d = w_fix_res;
`else
    w_res_d = w_fix_res;
`endif
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef MULDIV_FAST_PATH_EN
          if (funct3[2] ? (b == '0) : ((a == '0) || (b == '0)))
            w_next = S_DONE;
          else
            w_next = S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_opd <= '0;
      r_f3  <= '0;
      r_neg <= 1'b0;
      r_sa  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_cnt <= '0;
        r_f3  <= funct3;
        r_neg <= w_a_sgn ^ w_b_sgn;
        r_sa  <= w_a_sgn;
        r_opd <= funct3[2] ? w_b_mag : w_a_mag;
        r_acc <= {{WIDTH{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= r_f3[2] ? w_div_acc : w_mul_acc;
      end
    end
  end

  // Registered handshake outputs; result loads only on entry to DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= (w_next == S_CALC) || (w_next == S_FIX);
      r_done <= (w_next == S_DONE);
      if (w_next == S_DONE && r_state != S_DONE) r_result <= w_res_d;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
